load_ext_w: RTL and testbench

LOAD_EXT_W -- requirements
Module: load_ext_w

---
 rtl/load_ext_w.sv | 118 +++++++++++
 tb/tb_load_ext_w.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_ext_w.sv
// Write-back stage register and load extender: captures M-stage results, slices and
// extends load data, qualifies the register write and counts misaligned loads.
module load_ext_w #(
    parameter bit ADDR_CHECK = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Flush_W,
    input  logic [31:0] MemOut_M,
    input  logic [31:0] ALUOutput_M,
    input  logic [2:0]  LoadSel_M,
    input  logic        RegWrite_M,
    input  logic [4:0]  WriteReg_M,
    input  logic [31:0] PCPlus4_M,
    output logic [31:0] RFWD_W,
    output logic [4:0]  WriteReg_W,
    output logic        RegWrite_W,
    output logic [31:0] PCPlus4_W,
    output logic        LoadErr_W,
    output logic [7:0]  ErrCount
);

    localparam logic [2:0] SEL_ALU  = 3'b000;
    localparam logic [2:0] SEL_LW   = 3'b001;
    localparam logic [2:0] SEL_LB   = 3'b010;
    localparam logic [2:0] SEL_LBU  = 3'b011;
    localparam logic [2:0] SEL_LH   = 3'b100;
    localparam logic [2:0] SEL_LHU  = 3'b101;
    localparam logic [2:0] SEL_LINK = 3'b110;

    logic [31:0] mem_w;
    logic [31:0] alu_w;
    logic [2:0]  sel_w;
    logic        reg_write_w;
    logic [4:0]  write_reg_w;
    logic [31:0] pc_plus4_w;
    logic [7:0]  err_count;

    logic [7:0]  byte_data;
    logic [15:0] half_data;
    logic [31:0] result;
    logic        load_err;
    logic        write_en;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            mem_w       <= '0;
            alu_w       <= '0;
            sel_w       <= SEL_ALU;
            reg_write_w <= 1'b0;
            write_reg_w <= '0;
            pc_plus4_w  <= '0;
            err_count   <= '0;
        end else begin
            if (Flush_W) begin
                mem_w       <= '0;
                alu_w       <= '0;
                sel_w       <= SEL_ALU;
                reg_write_w <= 1'b0;
                write_reg_w <= '0;
                pc_plus4_w  <= '0;
            end else begin
                mem_w       <= MemOut_M;
                alu_w       <= ALUOutput_M;
                sel_w       <= LoadSel_M;
                reg_write_w <= RegWrite_M;
                write_reg_w <= WriteReg_M;
                pc_plus4_w  <= PCPlus4_M;
            end
            // The error being counted belongs to the instruction leaving W at this edge.
            if (load_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    always_comb begin
        byte_data = mem_w[7:0];
        case (alu_w[1:0])
            2'b00:   byte_data = mem_w[7:0];
            2'b01:   byte_data = mem_w[15:8];
            2'b10:   byte_data = mem_w[23:16];
            default: byte_data = mem_w[31:24];
        endcase
        half_data = alu_w[1] ? mem_w[31:16] : mem_w[15:0];

        result = alu_w;
        case (sel_w)
            SEL_LW:   result = mem_w;
            SEL_LB:   result = {{24{byte_data[7]}}, byte_data};
            SEL_LBU:  result = {24'h0, byte_data};
            SEL_LH:   result = {{16{half_data[15]}}, half_data};
            SEL_LHU:  result = {16'h0, half_data};
            SEL_LINK: result = pc_plus4_w + 32'd4;
            default:  result = alu_w;
        endcase

        load_err = 1'b0;
        if (ADDR_CHECK) begin
            if ((sel_w == SEL_LW) && (alu_w[1:0] != 2'b00)) begin
                load_err = 1'b1;
            end
            if (((sel_w == SEL_LH) || (sel_w == SEL_LHU)) && alu_w[0]) begin
                load_err = 1'b1;
            end
        end

        write_en = reg_write_w && !load_err && (write_reg_w != 5'd0);
    end

    assign RFWD_W     = write_en ? result : 32'h0;
    assign WriteReg_W = write_reg_w;
    assign RegWrite_W = write_en;
    assign PCPlus4_W  = pc_plus4_w;
    assign LoadErr_W  = load_err;
    assign ErrCount   = err_count;

endmodule

// File: tb/tb_load_ext_w.sv
// Directed bench for load_ext_w: one task per scenario, inline comparisons against
// hand-computed values, plus a second instance with the address check disabled.
module tb_load_ext_w;

    logic        CLK;
    logic        Reset;
    logic        Flush_W;
    logic [31:0] MemOut_M;
    logic [31:0] ALUOutput_M;
    logic [2:0]  LoadSel_M;
    logic        RegWrite_M;
    logic [4:0]  WriteReg_M;
    logic [31:0] PCPlus4_M;
    logic [31:0] RFWD_W;
    logic [4:0]  WriteReg_W;
    logic        RegWrite_W;
    logic [31:0] PCPlus4_W;
    logic        LoadErr_W;
    logic [7:0]  ErrCount;

    logic [31:0] nc_rfwd;
    logic [4:0]  nc_write_reg;
    logic        nc_reg_write;
    logic [31:0] nc_pc_plus4;
    logic        nc_load_err;
    logic [7:0]  nc_err_count;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] WORD = 32'h8081F2F3;

    load_ext_w #(.ADDR_CHECK(1'b1)) dut (
        .CLK(CLK), .Reset(Reset), .Flush_W(Flush_W),
        .MemOut_M(MemOut_M), .ALUOutput_M(ALUOutput_M), .LoadSel_M(LoadSel_M),
        .RegWrite_M(RegWrite_M), .WriteReg_M(WriteReg_M), .PCPlus4_M(PCPlus4_M),
        .RFWD_W(RFWD_W), .WriteReg_W(WriteReg_W), .RegWrite_W(RegWrite_W),
        .PCPlus4_W(PCPlus4_W), .LoadErr_W(LoadErr_W), .ErrCount(ErrCount)
    );

    load_ext_w #(.ADDR_CHECK(1'b0)) dut_nc (
        .CLK(CLK), .Reset(Reset), .Flush_W(Flush_W),
        .MemOut_M(MemOut_M), .ALUOutput_M(ALUOutput_M), .LoadSel_M(LoadSel_M),
        .RegWrite_M(RegWrite_M), .WriteReg_M(WriteReg_M), .PCPlus4_M(PCPlus4_M),
        .RFWD_W(nc_rfwd), .WriteReg_W(nc_write_reg), .RegWrite_W(nc_reg_write),
        .PCPlus4_W(nc_pc_plus4), .LoadErr_W(nc_load_err), .ErrCount(nc_err_count)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Apply one M-stage beat, let it cross the edge, and settle 1 ns past it.
    task automatic drive(input logic rst, input logic flush, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [2:0] sel, input logic rw,
                         input logic [4:0] wr, input logic [31:0] pc);
        Reset       = rst;
        Flush_W     = flush;
        MemOut_M    = mem;
        ALUOutput_M = alu;
        LoadSel_M   = sel;
        RegWrite_M  = rw;
        WriteReg_M  = wr;
        PCPlus4_M   = pc;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, WORD, 32'h0000_1000, 3'b001, 1'b1, 5'd9, 32'h0000_2004);
        checks++; if (RFWD_W !== 32'h0) begin errors++; $display("FAIL reset_rfwd got %h exp 0", RFWD_W); end
        checks++; if (WriteReg_W !== 5'd0) begin errors++; $display("FAIL reset_wreg got %0d exp 0", WriteReg_W); end
        checks++; if (RegWrite_W !== 1'b0) begin errors++; $display("FAIL reset_rw got %b exp 0", RegWrite_W); end
        checks++; if (PCPlus4_W !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", PCPlus4_W); end
        checks++; if (LoadErr_W !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", LoadErr_W); end
        checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", ErrCount); end
    endtask

    task automatic test_bytes();
        drive(1'b0, 1'b0, WORD, 32'h0000_1001, 3'b010, 1'b1, 5'd5, 32'h0000_0104);
        checks++; if (RFWD_W !== 32'hFFFF_FFF2) begin errors++; $display("FAIL lb_a1 got %h exp FFFFFFF2", RFWD_W); end
        checks++; if (RegWrite_W !== 1'b1) begin errors++; $display("FAIL lb_a1_rw got %b exp 1", RegWrite_W); end
        checks++; if (WriteReg_W !== 5'd5) begin errors++; $display("FAIL lb_a1_wreg got %0d exp 5", WriteReg_W); end
        checks++; if (PCPlus4_W !== 32'h0000_0104) begin errors++; $display("FAIL lb_a1_pc got %h exp 00000104", PCPlus4_W); end
        drive(1'b0, 1'b0, WORD, 32'h0000_1000, 3'b010, 1'b1, 5'd5, 32'h0);
        checks++; if (RFWD_W !== 32'hFFFF_FFF3) begin errors++; $display("FAIL lb_a0 got %h exp FFFFFFF3", RFWD_W); end
        drive(1'b0, 1'b0, WORD, 32'h0000_1002, 3'b011, 1'b1, 5'd5, 32'h0);
        checks++; if (RFWD_W !== 32'h0000_0081) begin errors++; $display("FAIL lbu_a2 got %h exp 00000081", RFWD_W); end
        drive(1'b0, 1'b0, WORD, 32'h0000_1003, 3'b011, 1'b1, 5'd5, 32'h0);
        checks++; if (RFWD_W !== 32'h0000_0080) begin errors++; $display("FAIL lbu_a3 got %h exp 00000080", RFWD_W); end
        drive(1'b0, 1'b0, WORD, 32'h0000_1003, 3'b010, 1'b1, 5'd5, 32'h0);
        checks++; if (RFWD_W !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_a3 got %h exp FFFFFF80", RFWD_W); end
    endtask

    task automatic test_halves();
        drive(1'b0, 1'b0, WORD, 32'h0000_2002, 3'b101, 1'b1, 5'd6, 32'h0);
        checks++; if (RFWD_W !== 32'h0000_8081) begin errors++; $display("FAIL lhu_a2 got %h exp 00008081", RFWD_W); end
        drive(1'b0, 1'b0, WORD, 32'h0000_2002, 3'b100, 1'b1, 5'd6, 32'h0);
        checks++; if (RFWD_W !== 32'hFFFF_8081) begin errors++; $display("FAIL lh_a2 got %h exp FFFF8081", RFWD_W); end
        drive(1'b0, 1'b0, WORD, 32'h0000_2000, 3'b100, 1'b1, 5'd6, 32'h0);
        checks++; if (RFWD_W !== 32'hFFFF_F2F3) begin errors++; $display("FAIL lh_a0 got %h exp FFFFF2F3", RFWD_W); end
        drive(1'b0, 1'b0, WORD, 32'h0000_2000, 3'b101, 1'b1, 5'd6, 32'h0);
        checks++; if (RFWD_W !== 32'h0000_F2F3) begin errors++; $display("FAIL lhu_a0 got %h exp 0000F2F3", RFWD_W); end
        checks++; if (LoadErr_W !== 1'b0) begin errors++; $display("FAIL lhu_a0_err got %b exp 0", LoadErr_W); end
    endtask

    task automatic test_word_alu();
        drive(1'b0, 1'b0, WORD, 32'h0000_0004, 3'b001, 1'b1, 5'd8, 32'h0);
        checks++; if (RFWD_W !== WORD) begin errors++; $display("FAIL lw_a4 got %h exp 8081F2F3", RFWD_W); end
        drive(1'b0, 1'b0, WORD, 32'hDEAD_BEEF, 3'b000, 1'b1, 5'd8, 32'h0);
        checks++; if (RFWD_W !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu got %h exp DEADBEEF", RFWD_W); end
        drive(1'b0, 1'b0, WORD, 32'h1234_5677, 3'b111, 1'b1, 5'd8, 32'h0);
        checks++; if (RFWD_W !== 32'h1234_5677) begin errors++; $display("FAIL reserved got %h exp 12345677", RFWD_W); end
        checks++; if (LoadErr_W !== 1'b0) begin errors++; $display("FAIL reserved_err got %b exp 0", LoadErr_W); end
        drive(1'b0, 1'b0, WORD, 32'h0000_0004, 3'b001, 1'b0, 5'd8, 32'h0);
        checks++; if (RFWD_W !== 32'h0) begin errors++; $display("FAIL no_rw_rfwd got %h exp 0", RFWD_W); end
        checks++; if (RegWrite_W !== 1'b0) begin errors++; $display("FAIL no_rw got %b exp 0", RegWrite_W); end
    endtask

    task automatic test_misaligned();
        do_reset();
        drive(1'b0, 1'b0, WORD, 32'h0000_0006, 3'b001, 1'b1, 5'd3, 32'h0);
        checks++; if (LoadErr_W !== 1'b1) begin errors++; $display("FAIL mis_lw_err got %b exp 1", LoadErr_W); end
        checks++; if (RegWrite_W !== 1'b0) begin errors++; $display("FAIL mis_lw_rw got %b exp 0", RegWrite_W); end
        checks++; if (RFWD_W !== 32'h0) begin errors++; $display("FAIL mis_lw_rfwd got %h exp 0", RFWD_W); end
        checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL mis_lw_cnt0 got %0d exp 0", ErrCount); end
        checks++; if (nc_load_err !== 1'b0) begin errors++; $display("FAIL nochk_err got %b exp 0", nc_load_err); end
        checks++; if (nc_rfwd !== WORD) begin errors++; $display("FAIL nochk_rfwd got %h exp 8081F2F3", nc_rfwd); end
        checks++; if (nc_reg_write !== 1'b1) begin errors++; $display("FAIL nochk_rw got %b exp 1", nc_reg_write); end
        drive(1'b0, 1'b0, WORD, 32'h0000_0001, 3'b100, 1'b1, 5'd3, 32'h0);
        checks++; if (ErrCount !== 8'd1) begin errors++; $display("FAIL mis_cnt1 got %0d exp 1", ErrCount); end
        checks++; if (LoadErr_W !== 1'b1) begin errors++; $display("FAIL mis_lh_err got %b exp 1", LoadErr_W); end
        drive(1'b0, 1'b0, WORD, 32'h0000_0003, 3'b101, 1'b1, 5'd3, 32'h0);
        checks++; if (LoadErr_W !== 1'b1) begin errors++; $display("FAIL mis_lhu_err got %b exp 1", LoadErr_W); end
        checks++; if (ErrCount !== 8'd2) begin errors++; $display("FAIL mis_cnt2 got %0d exp 2", ErrCount); end
        drive(1'b0, 1'b0, WORD, 32'h0000_0001, 3'b010, 1'b1, 5'd7, 32'h0);
        checks++; if (LoadErr_W !== 1'b0) begin errors++; $display("FAIL lb_odd_err got %b exp 0", LoadErr_W); end
        checks++; if (ErrCount !== 8'd3) begin errors++; $display("FAIL mis_cnt3 got %0d exp 3", ErrCount); end
        checks++; if (nc_err_count !== 8'd0) begin errors++; $display("FAIL nochk_cnt got %0d exp 0", nc_err_count); end
        idle();
        checks++; if (ErrCount !== 8'd3) begin errors++; $display("FAIL mis_cnt_hold got %0d exp 3", ErrCount); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, WORD, 32'h0000_0006, 3'b001, 1'b1, 5'd4, 32'h0);
        end
        checks++; if (ErrCount !== 8'd9) begin errors++; $display("FAIL sat_cnt9 got %0d exp 9", ErrCount); end
        for (int i = 10; i < 300; i++) begin
            drive(1'b0, 1'b0, WORD, 32'h0000_0006, 3'b001, 1'b1, 5'd4, 32'h0);
        end
        idle();
        checks++; if (ErrCount !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d exp 255", ErrCount); end
        drive(1'b0, 1'b0, WORD, 32'h0000_0005, 3'b001, 1'b1, 5'd4, 32'h0);
        idle();
        checks++; if (ErrCount !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", ErrCount); end
        do_reset();
        checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL sat_reset got %0d exp 0", ErrCount); end
    endtask

    task automatic test_link();
        drive(1'b0, 1'b0, WORD, 32'h0000_0007, 3'b110, 1'b1, 5'd31, 32'h0000_3004);
        checks++; if (RFWD_W !== 32'h0000_3008) begin errors++; $display("FAIL link got %h exp 00003008", RFWD_W); end
        checks++; if (WriteReg_W !== 5'd31) begin errors++; $display("FAIL link_wreg got %0d exp 31", WriteReg_W); end
        checks++; if (LoadErr_W !== 1'b0) begin errors++; $display("FAIL link_err got %b exp 0", LoadErr_W); end
        drive(1'b0, 1'b0, WORD, 32'h0, 3'b110, 1'b1, 5'd0, 32'h0000_3004);
        checks++; if (RegWrite_W !== 1'b0) begin errors++; $display("FAIL link_r0_rw got %b exp 0", RegWrite_W); end
        checks++; if (RFWD_W !== 32'h0) begin errors++; $display("FAIL link_r0_rfwd got %h exp 0", RFWD_W); end
        drive(1'b0, 1'b0, WORD, 32'h0, 3'b110, 1'b1, 5'd31, 32'hFFFF_FFFC);
        checks++; if (RFWD_W !== 32'h0) begin errors++; $display("FAIL link_wrap got %h exp 0", RFWD_W); end
        checks++; if (RegWrite_W !== 1'b1) begin errors++; $display("FAIL link_wrap_rw got %b exp 1", RegWrite_W); end
    endtask

    task automatic test_flush_reset();
        do_reset();
        drive(1'b0, 1'b1, WORD, 32'h0000_0004, 3'b001, 1'b1, 5'd12, 32'h0000_4004);
        checks++; if (RFWD_W !== 32'h0) begin errors++; $display("FAIL flush_rfwd got %h exp 0", RFWD_W); end
        checks++; if (WriteReg_W !== 5'd0) begin errors++; $display("FAIL flush_wreg got %0d exp 0", WriteReg_W); end
        checks++; if (RegWrite_W !== 1'b0) begin errors++; $display("FAIL flush_rw got %b exp 0", RegWrite_W); end
        checks++; if (PCPlus4_W !== 32'h0) begin errors++; $display("FAIL flush_pc got %h exp 0", PCPlus4_W); end
        drive(1'b0, 1'b0, WORD, 32'h0000_0006, 3'b001, 1'b1, 5'd12, 32'h0000_4004);
        checks++; if (LoadErr_W !== 1'b1) begin errors++; $display("FAIL pre_rf_err got %b exp 1", LoadErr_W); end
        // Reset and flush together with a pending error: reset must clear the count too.
        drive(1'b1, 1'b1, WORD, 32'h0000_0004, 3'b001, 1'b1, 5'd12, 32'h0000_4004);
        checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL rf_cnt got %0d exp 0", ErrCount); end
        checks++; if (RFWD_W !== 32'h0) begin errors++; $display("FAIL rf_rfwd got %h exp 0", RFWD_W); end
        checks++; if (PCPlus4_W !== 32'h0) begin errors++; $display("FAIL rf_pc got %h exp 0", PCPlus4_W); end
        checks++; if (LoadErr_W !== 1'b0) begin errors++; $display("FAIL rf_err got %b exp 0", LoadErr_W); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b0, WORD, 32'h0000_0010, 3'b001, 1'b1, 5'd1, 32'h0000_0014);
        checks++; if (RFWD_W !== WORD) begin errors++; $display("FAIL b2b_0 got %h exp 8081F2F3", RFWD_W); end
        drive(1'b0, 1'b0, 32'h0000_7F00, 32'h0000_0011, 3'b010, 1'b1, 5'd2, 32'h0000_0018);
        checks++; if (RFWD_W !== 32'h0000_007F) begin errors++; $display("FAIL b2b_1 got %h exp 0000007F", RFWD_W); end
        checks++; if (WriteReg_W !== 5'd2) begin errors++; $display("FAIL b2b_1_wreg got %0d exp 2", WriteReg_W); end
        drive(1'b0, 1'b0, 32'h7FFF_0000, 32'h0000_0012, 3'b100, 1'b1, 5'd3, 32'h0000_001C);
        checks++; if (RFWD_W !== 32'h0000_7FFF) begin errors++; $display("FAIL b2b_2 got %h exp 00007FFF", RFWD_W); end
        checks++; if (PCPlus4_W !== 32'h0000_001C) begin errors++; $display("FAIL b2b_2_pc got %h exp 0000001C", PCPlus4_W); end
        // Reset arriving while a valid load is presented: nothing may be written next cycle.
        drive(1'b1, 1'b0, WORD, 32'h0000_0020, 3'b001, 1'b1, 5'd4, 32'h0000_0024);
        checks++; if (RegWrite_W !== 1'b0) begin errors++; $display("FAIL midrst_rw got %b exp 0", RegWrite_W); end
        checks++; if (RFWD_W !== 32'h0) begin errors++; $display("FAIL midrst_rfwd got %h exp 0", RFWD_W); end
    endtask

    initial begin
        Reset = 1'b1; Flush_W = 1'b0; MemOut_M = '0; ALUOutput_M = '0;
        LoadSel_M = '0; RegWrite_M = 1'b0; WriteReg_M = '0; PCPlus4_M = '0;
        @(negedge CLK);
        test_reset();
        test_bytes();
        test_halves();
        test_word_alu();
        test_misaligned();
        test_saturate();
        test_link();
        test_flush_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
